// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the RAM port arbiter and its lane unit.
package mem_ctrl_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
  typedef enum logic [2:0] {IDLE, CHECK, ACCESS, WRITE, RESP} state_e;
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: sub-word store merge, load extract/extend and alignment check.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] extracted,
  output logic        misalign
);
  logic [4:0]  sh;
  logic [31:0] mask, lane_data, shifted;
  always_comb begin
    sh = (size == SZ_H) ? {off[1], 4'b0000} : {off, 3'b000};
    mask = (size == SZ_B) ? 32'h0000_00FF << sh : (size == SZ_H) ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    lane_data = (size == SZ_B) ? {24'b0, wdata[7:0]} << sh : (size == SZ_H) ? {16'b0, wdata[15:0]} << sh : wdata;
    merged = (word & ~mask) | (lane_data & mask);
    shifted = word >> {off, 3'b000};
    extracted = (size == SZ_B) ? {{24{shifted[7] & ~uns}}, shifted[7:0]} :
                (size == SZ_H) ? {{16{shifted[15] & ~uns}}, shifted[15:0]} : shifted;
    misalign = (size == SZ_X) || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the word-only RAM port between two requesters and
// adds sub-word loads/stores via read-modify-write.
module ram_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic              m0_req_we_i,
  input  logic [1:0]        m0_req_size_i,
  input  logic              m0_req_unsigned_i,
  input  logic [ADDR_W-1:0] m0_req_addr_i,
  input  logic [31:0]       m0_req_wdata_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [31:0]       m0_rsp_rdata_o,
  output logic              m0_rsp_err_o,
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic              m1_req_we_i,
  input  logic [1:0]        m1_req_size_i,
  input  logic              m1_req_unsigned_i,
  input  logic [ADDR_W-1:0] m1_req_addr_i,
  input  logic [31:0]       m1_req_wdata_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [31:0]       m1_rsp_rdata_o,
  output logic              m1_rsp_err_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [31:0]       ram_wr_data_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [31:0]       ram_rd_data_i
);
  state_e state, state_d;
  logic owner, rr, we_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q, aligned;
  logic [31:0] wdata_q, rdata_q, wr_q, merged, extracted;
  logic misalign, grant, win, rsp_ready, resp_live;

  mem_lane_unit u_lane (
    .word      (ram_rd_data_i),
    .wdata     (wdata_q),
    .size      (size_q),
    .off       (addr_q[1:0]),
    .uns       (uns_q),
    .merged    (merged),
    .extracted (extracted),
    .misalign  (misalign)
  );

  assign aligned = {addr_q[ADDR_W-1:2], 2'b00};

  // Outputs are gated by rst_i so a reset landing in WRITE suppresses the store.
  always_comb begin
    grant = !rst_i && state == IDLE && (m0_req_valid_i || m1_req_valid_i);
    win = (m0_req_valid_i && m1_req_valid_i) ? (FIXED_PRIO ? OWN_M0 : rr) : m1_req_valid_i;
    rsp_ready = (owner == OWN_M1) ? m1_rsp_ready_i : m0_rsp_ready_i;
    resp_live = !rst_i && state == RESP;
    m0_req_ready_o = grant && win == OWN_M0;
    m1_req_ready_o = grant && win == OWN_M1;
    m0_rsp_valid_o = resp_live && owner == OWN_M0;
    m1_rsp_valid_o = resp_live && owner == OWN_M1;
    m0_rsp_rdata_o = m0_rsp_valid_o ? rdata_q : 32'h0;
    m1_rsp_rdata_o = m1_rsp_valid_o ? rdata_q : 32'h0;
    m0_rsp_err_o = m0_rsp_valid_o && err_q;
    m1_rsp_err_o = m1_rsp_valid_o && err_q;
    ram_rd_en_o = !rst_i && state == ACCESS;
    ram_rd_addr_o = ram_rd_en_o ? aligned : '0;
    ram_wr_en_o = !rst_i && state == WRITE;
    ram_wr_addr_o = ram_wr_en_o ? aligned : '0;
    ram_wr_data_o = ram_wr_en_o ? wr_q : 32'h0;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = grant ? CHECK : IDLE;
      CHECK:   state_d = misalign ? RESP : ACCESS;
      ACCESS:  state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner   <= OWN_M0;
      rr      <= OWN_M0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      wr_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner   <= win;
          we_q    <= win ? m1_req_we_i : m0_req_we_i;
          size_q  <= win ? m1_req_size_i : m0_req_size_i;
          uns_q   <= win ? m1_req_unsigned_i : m0_req_unsigned_i;
          addr_q  <= win ? m1_req_addr_i : m0_req_addr_i;
          wdata_q <= win ? m1_req_wdata_i : m0_req_wdata_i;
        end
        CHECK: begin
          err_q   <= misalign;
          rdata_q <= 32'h0;
        end
        ACCESS: begin
          rdata_q <= we_q ? 32'h0 : extracted;
          wr_q    <= merged;
        end
        RESP: if (rsp_ready) rr <= ~owner;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven vectors plus arbitration, backpressure and reset sequences.
module tb_ram_port_arbiter;
  import mem_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  logic m0_req_valid = 0, m0_req_we = 0, m0_req_unsigned = 0, m0_rsp_ready = 1;
  logic m1_req_valid = 0, m1_req_we = 0, m1_req_unsigned = 0, m1_rsp_ready = 1;
  logic [1:0] m0_req_size = 0, m1_req_size = 0;
  logic [31:0] m0_req_addr = 0, m1_req_addr = 0, m0_req_wdata = 0, m1_req_wdata = 0;
  logic m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic ram_wr_en, ram_rd_en;
  logic [31:0] ram_wr_addr, ram_rd_addr, ram_wr_data, ram_rd_data;
  logic f0_rdy, f1_rdy, f0_rv, f1_rv, f0_err, f1_err, f_we, f_re;
  logic [31:0] f0_rd, f1_rd, f_wa, f_ra, f_wd;
  logic [31:0] mem [64] = '{default: 32'h0};
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr[7:2]] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr[7:2]];
  always @(negedge clk) begin
    if (ram_wr_en) wr_cnt <= wr_cnt + 1;
    if (ram_rd_en) rd_cnt <= rd_cnt + 1;
  end

  ram_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready), .m0_req_we_i(m0_req_we),
    .m0_req_size_i(m0_req_size), .m0_req_unsigned_i(m0_req_unsigned), .m0_req_addr_i(m0_req_addr),
    .m0_req_wdata_i(m0_req_wdata), .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready),
    .m0_rsp_rdata_o(m0_rsp_rdata), .m0_rsp_err_o(m0_rsp_err),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready), .m1_req_we_i(m1_req_we),
    .m1_req_size_i(m1_req_size), .m1_req_unsigned_i(m1_req_unsigned), .m1_req_addr_i(m1_req_addr),
    .m1_req_wdata_i(m1_req_wdata), .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready),
    .m1_rsp_rdata_o(m1_rsp_rdata), .m1_rsp_err_o(m1_rsp_err),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data)
  );

  ram_port_arbiter #(.FIXED_PRIO(1'b1)) fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(f0_rdy), .m0_req_we_i(m0_req_we),
    .m0_req_size_i(m0_req_size), .m0_req_unsigned_i(m0_req_unsigned), .m0_req_addr_i(m0_req_addr),
    .m0_req_wdata_i(m0_req_wdata), .m0_rsp_valid_o(f0_rv), .m0_rsp_ready_i(m0_rsp_ready),
    .m0_rsp_rdata_o(f0_rd), .m0_rsp_err_o(f0_err),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(f1_rdy), .m1_req_we_i(m1_req_we),
    .m1_req_size_i(m1_req_size), .m1_req_unsigned_i(m1_req_unsigned), .m1_req_addr_i(m1_req_addr),
    .m1_req_wdata_i(m1_req_wdata), .m1_rsp_valid_o(f1_rv), .m1_rsp_ready_i(m1_rsp_ready),
    .m1_rsp_rdata_o(f1_rd), .m1_rsp_err_o(f1_err),
    .ram_wr_en_o(f_we), .ram_wr_addr_o(f_wa), .ram_wr_data_o(f_wd),
    .ram_rd_en_o(f_re), .ram_rd_addr_o(f_ra), .ram_rd_data_i(32'h0)
  );

  typedef struct {
    int p; logic we; logic [1:0] sz; logic u; logic [31:0] a, wd, rd;
    logic er; int lat, nrd, nwr; logic [31:0] mw;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req_valid = v; m0_req_we = we; m0_req_size = sz; m0_req_unsigned = u; m0_req_addr = a; m0_req_wdata = wd;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_size = sz; m1_req_unsigned = u; m1_req_addr = a; m1_req_wdata = wd;
    end
  endtask

  task automatic req(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
    bit ok = 0;
    int t0 = 0;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    drive(v.p, 1, v.we, v.sz, v.u, v.a, v.wd);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((v.p == 0) ? m0_req_ready : m1_req_ready) begin ok = 1; t0 = cyc; end
    end
    @(posedge clk); #1;
    drive(v.p, 0, 0, SZ_W, 0, 0, 0);
    check("accept_timeout", {31'b0, ok}, 32'h1);
    ok = 0; rd = 32'hx; er = 1'bx; lat = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((v.p == 0) ? m0_rsp_valid : m1_rsp_valid) begin
        rd = (v.p == 0) ? m0_rsp_rdata : m1_rsp_rdata;
        er = (v.p == 0) ? m0_rsp_err : m1_rsp_err;
        lat = cyc - t0; ok = 1;
      end
    end
    check("rsp_timeout", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, r0, w0, n_rr, n_fp, k;
    int g_rr [4], g_fp [4];
    bit ok;
    tbl[0]  = '{0, 1, SZ_W, 0, 32'h20,       32'h11223344, 32'h0,        0, 4, 1, 1, 32'h11223344};
    tbl[1]  = '{0, 1, SZ_W, 0, 32'h20000010, 32'hDEADBEEF, 32'h0,        0, 4, 1, 1, 32'hDEADBEEF};
    tbl[2]  = '{0, 0, SZ_W, 0, 32'h20000010, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 1, SZ_B, 0, 32'h22,       32'h123456AA, 32'h0,        0, 4, 1, 1, 32'h11AA3344};
    tbl[4]  = '{0, 0, SZ_B, 0, 32'h22,       32'h0,        32'hFFFFFFAA, 0, 3, 1, 0, 32'h11AA3344};
    tbl[5]  = '{0, 0, SZ_B, 1, 32'h22,       32'h0,        32'h000000AA, 0, 3, 1, 0, 32'h11AA3344};
    tbl[6]  = '{0, 1, SZ_H, 0, 32'h32,       32'hFFFF8001, 32'h0,        0, 4, 1, 1, 32'h80010000};
    tbl[7]  = '{0, 0, SZ_H, 0, 32'h32,       32'h0,        32'hFFFF8001, 0, 3, 1, 0, 32'h80010000};
    tbl[8]  = '{0, 0, SZ_H, 1, 32'h32,       32'h0,        32'h00008001, 0, 3, 1, 0, 32'h80010000};
    tbl[9]  = '{0, 0, SZ_W, 0, 32'h41,       32'h0,        32'h0,        1, 2, 0, 0, 32'h0};
    tbl[10] = '{0, 1, SZ_H, 0, 32'h43,       32'h0000FFFF, 32'h0,        1, 2, 0, 0, 32'h0};
    tbl[11] = '{0, 0, SZ_X, 0, 32'h40,       32'h0,        32'h0,        1, 2, 0, 0, 32'h0};
    tbl[12] = '{1, 0, SZ_B, 0, 32'h23,       32'h0,        32'h00000011, 0, 3, 1, 0, 32'h11AA3344};
    tbl[13] = '{1, 1, SZ_B, 0, 32'h20,       32'h00000080, 32'h0,        0, 4, 1, 1, 32'h11AA3380};
    tbl[14] = '{1, 0, SZ_H, 0, 32'h20,       32'h0,        32'h00003380, 0, 3, 1, 0, 32'h11AA3380};
    tbl[15] = '{1, 0, SZ_B, 0, 32'h20,       32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 32'h11AA3380};

    m0_req_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, m0_req_ready}, 32'h0);
    check("rst_rsp_valid", {30'b0, m0_rsp_valid, m1_rsp_valid}, 32'h0);
    check("rst_ram_en", {30'b0, ram_wr_en, ram_rd_en}, 32'h0);
    check("rst_ram_addr", ram_wr_addr | ram_rd_addr | ram_wr_data, 32'h0);
    @(posedge clk); #1 m0_req_valid = 0; rst = 0;

    foreach (tbl[i]) begin
      r0 = rd_cnt; w0 = wr_cnt;
      req(tbl[i], rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_rd_en", i), rd_cnt - r0, tbl[i].nrd);
      check($sformatf("v%0d_wr_en", i), wr_cnt - w0, tbl[i].nwr);
      check($sformatf("v%0d_mem", i), mem[tbl[i].a[7:2]], tbl[i].mw);
    end

    // Both requesters held valid: round-robin alternates, fixed priority keeps m0.
    do_reset();
    drive(0, 1, 0, SZ_W, 0, 32'h10, 0);
    drive(1, 1, 0, SZ_W, 0, 32'h10, 0);
    n_rr = 0; n_fp = 0;
    for (int i = 0; i < 80 && (n_rr < 4 || n_fp < 4); i++) begin
      @(negedge clk);
      if (n_rr < 4 && (m0_req_ready || m1_req_ready)) begin g_rr[n_rr] = m1_req_ready; n_rr++; end
      if (n_fp < 4 && (f0_rdy || f1_rdy)) begin g_fp[n_fp] = f1_rdy; n_fp++; end
    end
    check("rr_grant_count", n_rr, 4);
    check("fp_grant_count", n_fp, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), i < n_rr ? g_rr[i] : -1, i % 2);
      check($sformatf("fp_grant%0d", i), i < n_fp ? g_fp[i] : -1, 0);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, SZ_W, 0, 0, 0);
    drive(1, 0, 0, SZ_W, 0, 0, 0);
    repeat (8) @(posedge clk);

    // Response backpressure holds data and blocks the other requester.
    do_reset();
    m0_rsp_ready = 0; m1_rsp_ready = 1;
    drive(0, 1, 0, SZ_W, 0, 32'h10, 0);
    drive(1, 1, 0, SZ_W, 0, 32'h20, 0);
    @(negedge clk);
    check("bp_grant_m0", {30'b0, m1_req_ready, m0_req_ready}, 32'h1);
    @(posedge clk); #1 drive(0, 0, 0, SZ_W, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = m0_rsp_valid;
    end
    check("bp_rsp_seen", {31'b0, ok}, 32'h1);
    for (k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid_held", {31'b0, m0_rsp_valid}, 32'h1);
      check("bp_rdata_held", m0_rsp_rdata, 32'hDEADBEEF);
      check("bp_m1_blocked", {31'b0, m1_req_ready}, 32'h0);
    end
    @(posedge clk); #1 m0_rsp_ready = 1;
    @(negedge clk);
    check("bp_hs_m1_blocked", {31'b0, m1_req_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_m1_granted_after", {31'b0, m1_req_ready}, 32'h1);
    @(posedge clk); #1 drive(1, 0, 0, SZ_W, 0, 0, 0);
    repeat (8) @(posedge clk);

    // Reset during the WRITE of a byte store from m1, with rr pointing at m1.
    do_reset();
    req('{0, 0, SZ_W, 0, 32'h10, 32'h0, 32'h0, 0, 3, 1, 0, 32'h0}, rd, er, lat);
    drive(1, 1, 1, SZ_B, 0, 32'h22, 32'h55);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = m1_req_ready;
    end
    check("rm_accept", {31'b0, ok}, 32'h1);
    @(posedge clk); #1 drive(1, 0, 0, SZ_W, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = ram_wr_en;
    end
    check("rm_write_seen", {31'b0, ok}, 32'h1);
    rst = 1;
    #1 check("rm_wr_suppressed", {31'b0, ram_wr_en}, 32'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rm_mem_unchanged", mem[8], 32'h11AA3380);
    check("rm_outputs_zero", {28'b0, m0_rsp_valid, m1_rsp_valid, ram_wr_en, ram_rd_en}, 32'h0);
    check("rm_data_zero", m1_rsp_rdata | ram_wr_data | ram_wr_addr, 32'h0);
    @(posedge clk); #1;
    drive(0, 1, 0, SZ_W, 0, 32'h10, 0);
    drive(1, 1, 0, SZ_W, 0, 32'h10, 0);
    @(negedge clk);
    check("rm_first_grant_m0", {30'b0, m1_req_ready, m0_req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 0, SZ_W, 0, 0, 0);
    drive(1, 0, 0, SZ_W, 0, 0, 0);
    repeat (8) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data-RAM read/write port of the memory model between two requesters: m0 = core load/store unit, m1 = debug/loader.
- Adds sub-word access (SB/SH/LB/LH/LBU/LHU) on top of the word-only RAM port:
  - sub-word stores use read-modify-write;
  - sub-word loads are extracted and sign- or zero-extended.
- Sits between the core LSU and the memory block; drives its ram_* inputs.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins.
- ADDR_W, 32: request/RAM address width.

Ports:
- clk_i  in  1  clock, single domain.
- rst_i  in  1  reset, synchronous, active-high.
- Per requester, x in {0,1}:
  - mx_req_valid_i  in  1  request valid.
  - mx_req_ready_o  out  1  request accepted this cycle.
  - mx_req_we_i  in  1  1 = store, 0 = load.
  - mx_req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
  - mx_req_unsigned_i  in  1  zero-extend loads (LBU/LHU).
  - mx_req_addr_i  in  ADDR_W  byte address.
  - mx_req_wdata_i  in  32  store data, right-aligned.
  - mx_rsp_valid_o  out  1  response valid.
  - mx_rsp_ready_i  in  1  response consumed.
  - mx_rsp_rdata_o  out  32  load data, extended; 0 for stores.
  - mx_rsp_err_o  out  1  misaligned or illegal size.
- RAM side:
  - ram_wr_en_o  out  1  RAM write enable.
  - ram_wr_addr_o  out  ADDR_W  word-aligned write address (bits [1:0] = 0).
  - ram_wr_data_o  out  32  merged write word.
  - ram_rd_en_o  out  1  RAM read enable.
  - ram_rd_addr_o  out  ADDR_W  word-aligned read address.
  - ram_rd_data_i  in  32  combinational RAM read data.

Behaviour:
- Reset: synchronous on rst_i.
  - State goes to IDLE; rr pointer = m0.
  - All *_ready_o, *_rsp_valid_o, rsp_err, rsp_rdata, ram_*_en_o, ram_* addr/data = 0.
  - Reset asserted in any state aborts the transaction; no RAM write is issued in that cycle.
- IDLE: arbitrate among asserted mx_req_valid_i.
  - Round-robin: the rr pointer port wins on a tie; the pointer flips to the other port after its response handshakes.
  - FIXED_PRIO=1: m0 wins every tie.
  - Winner gets mx_req_ready_o=1 for exactly this cycle (combinational on valid). Addr, we, size, unsigned, wdata and owner are latched. Next state CHECK.
  - The loser sees ready=0 and must hold its request.
- CHECK: alignment check on the latched request.
  - size=3, or half with addr[0]=1, or word with addr[1:0]!=0: err=1, rdata=0, go RESP. No RAM access.
  - Otherwise go ACCESS.
- ACCESS: ram_rd_en_o=1, ram_rd_addr_o={addr[ADDR_W-1:2],2'b00}; sample ram_rd_data_i.
  - Load: rdata = word >> (addr[1:0]*8), truncated to size, sign-extended unless unsigned; go RESP.
  - Store: merge wdata into the sampled word at lane addr[1:0] (byte: 1 lane; half: lanes addr[1]*2..+1; word: replace all); go WRITE.
- WRITE: ram_wr_en_o=1, same aligned address, merged word on ram_wr_data_o; go RESP.
- RESP: owner's mx_rsp_valid_o=1, holding rdata/err stable until mx_rsp_ready_i=1; then IDLE.
  - Only one request is ever outstanding.
  - New requests are not accepted until the cycle after the response handshake.
- Latency from accept cycle T (rsp_ready tied high):
  - load rsp_valid at T+3;
  - store rsp_valid at T+4;
  - error rsp_valid at T+2.
- Non-owner rsp_valid_o is always 0. RAM enables are 0 outside ACCESS/WRITE.
- A write-then-read to the same word from different requesters is ordered by acceptance; no bypass is needed because the write completes before RESP.

Decomposition:
- Package mem_ctrl_pkg:
  - size encodings SZ_B/SZ_H/SZ_W;
  - FSM state encodings IDLE/CHECK/ACCESS/WRITE/RESP;
  - owner encoding.
- Sub-module mem_lane_unit, combinational:
  - store merge (old word, wdata, size, addr[1:0]) → new word;
  - load extract (word, size, unsigned, addr[1:0]) → extended data;
  - misalign flag.

Test Plan:
- Word store then load: m0 SW 0x2000_0010 ← 0xDEADBEEF, then LW. Write must be 0xDEADBEEF at 0x10 (write latency T+4); load rsp_rdata=0xDEADBEEF, err=0.
- Byte RMW: preload word 0x11223344 at 0x20. SB addr 0x22 data 0xAA → word 0x11AA3344. LB 0x22 → 0xFFFFFFAA; LBU 0x22 → 0x000000AA.
- Half access: SH addr 0x32 data 0x8001 → upper half written. LH 0x32 → 0xFFFF8001; LHU → 0x00008001.
- Misaligned/illegal: LW addr 0x41, SH addr 0x43, size=3 → each gives err=1, rdata=0, valid at T+2, ram_wr_en_o/ram_rd_en_o never asserted.
- Arbitration: m0 and m1 both valid continuously.
  - Round-robin: grants alternate m0,m1,m0,m1.
  - FIXED_PRIO=1: m0 is granted every time.
  - Response backpressure (rsp_ready=0 for 5 cycles) holds rsp_valid and data stable and blocks the other requester.
- Reset mid-op: assert rst_i during WRITE of an SB → RAM word unchanged, all outputs 0 the next cycle, the first grant after reset goes to m0.
